// File: rtl/pair_trace_capture.sv
// pair_trace_capture: samples an (i, j) counter pair every cycle, timestamps each
// change of value and queues it in a FIFO drained over a valid/ready port. It also
// flags illegal steps of i and counts captures lost to a full FIFO.
module pair_trace_capture #(
    parameter  int W     = 15,
    parameter  int DEPTH = 16,
    parameter  int TSW   = 16,
    parameter  int CW    = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [W-1:0]   i,
    input  logic [W-1:0]   j,
    input  logic           freeze,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_i,
    output logic [W-1:0]   out_j,
    output logic [TSW-1:0] out_ts,
    output logic           step_err,
    output logic [CW-1:0]  dropped,
    output logic [LW-1:0]  level
);

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    typedef struct packed {
        logic [W-1:0]   i;
        logic [W-1:0]   j;
        logic [TSW-1:0] ts;
    } entry_t;

    state_t         state_q, state_d;
    logic [W-1:0]   last_i_q, last_i_d;
    logic [W-1:0]   last_j_q, last_j_d;
    logic [TSW-1:0] ts_q, ts_d;
    logic           step_err_q, step_err_d;
    logic [CW-1:0]  dropped_q, dropped_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    entry_t         mem_q [DEPTH];

    logic           capture;
    logic           pop;
    logic           full;
    logic           push;
    logic           drop;
    logic [W-1:0]   last_i_inc;

    // Tracking FSM, step check, FIFO bookkeeping and counters for the coming edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        last_i_d   = last_i_q;
        last_j_d   = last_j_q;
        step_err_d = step_err_q;
        capture    = 1'b0;
        last_i_inc = last_i_q + {{(W-1){1'b0}}, 1'b1};

        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    capture = 1'b1;
                    state_d = TRACK;
                end
                TRACK: begin
                    if ((i != last_i_q) || (j != last_j_q)) begin
                        capture = 1'b1;
                    end
                    // Holding or advancing by one (including the all-ones -> 0 wrap) is legal.
                    if ((i != last_i_q) && (i != last_i_inc)) begin
                        step_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The reference pair follows every capture, even one discarded by freeze.
        if (capture) begin
            last_i_d = i;
            last_j_d = j;
        end

        pop  = (level_q != '0) && out_ready;
        full = (level_q == LW'(DEPTH));
        // A pop on the same edge frees the slot, so a full FIFO can still accept.
        push = capture && !freeze && (!full || pop);
        drop = capture && !freeze && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        dropped_d = (drop && (dropped_q != '1)) ? dropped_q + CW'(1) : dropped_q;
        ts_d      = ts_q + TSW'(1);
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_i_q   <= '0;
            last_j_q   <= '0;
            ts_q       <= '0;
            step_err_q <= 1'b0;
            dropped_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q    <= state_d;
            last_i_q   <= last_i_d;
            last_j_q   <= last_j_d;
            ts_q       <= ts_d;
            step_err_q <= step_err_d;
            dropped_q  <= dropped_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // FIFO storage: write the sampled pair with the timestamp of the sampling cycle.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; level/pointers define validity, so stale data is never seen.
        if (push) begin
            mem_q[wr_ptr_q] <= '{i: i, j: j, ts: ts_q};
        end
    end

    assign out_valid = (level_q != '0);
    assign out_i     = mem_q[rd_ptr_q].i;
    assign out_j     = mem_q[rd_ptr_q].j;
    assign out_ts    = mem_q[rd_ptr_q].ts;
    assign step_err  = step_err_q;
    assign dropped   = dropped_q;
    assign level     = level_q;

endmodule

// File: tb/tb_pair_trace_capture.sv
// Bench for pair_trace_capture: directed scenarios plus a randomized run, checked
// against a behavioural model. Expected FIFO entries go into a scoreboard queue that
// a separate monitor pops whenever the DUT presents a head entry.
module tb_pair_trace_capture;

    localparam int W     = 15;
    localparam int DEPTH = 16;
    localparam int TSW   = 16;
    localparam int CW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int DMAX  = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   i = '0;
    logic [W-1:0]   j = '0;
    logic           freeze = 1'b0;
    logic           out_ready = 1'b0;
    logic           out_valid;
    logic [W-1:0]   out_i;
    logic [W-1:0]   out_j;
    logic [TSW-1:0] out_ts;
    logic           step_err;
    logic [CW-1:0]  dropped;
    logic [LW-1:0]  level;

    pair_trace_capture #(.W(W), .DEPTH(DEPTH), .TSW(TSW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .i         (i),
        .j         (j),
        .freeze    (freeze),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_j     (out_j),
        .out_ts    (out_ts),
        .step_err  (step_err),
        .dropped   (dropped),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int j;
        int ts;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state.
    bit m_has_last;
    int m_last_i;
    int m_last_j;
    int m_level;
    int m_dropped;
    bit m_step;
    int m_ts;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        freeze    = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        m_has_last = 1'b0;
        m_last_i   = 0;
        m_last_j   = 0;
        m_level    = 0;
        m_dropped  = 0;
        m_step     = 1'b0;
        m_ts       = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_dropped", dropped, 0);
        check("rst_step_err", step_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, predict the edge, then compare status after it.
    task automatic cycle(input bit v, input int ii, input int jj, input bit frz, input bit rdy);
        bit   cap;
        bit   pop;
        bit   pushed;
        exp_t e;
        ii        = ii % (1 << W);
        jj        = jj % (1 << W);
        in_valid  = v;
        i         = ii[W-1:0];
        j         = jj[W-1:0];
        freeze    = frz;
        out_ready = rdy;

        cap = 1'b0;
        if (v) begin
            if (!m_has_last) begin
                cap = 1'b1;
            end else begin
                if (ii != m_last_i || jj != m_last_j) cap = 1'b1;
                if (ii != m_last_i && ii != (m_last_i + 1) % (1 << W)) m_step = 1'b1;
            end
        end
        if (cap) begin
            m_has_last = 1'b1;
            m_last_i   = ii;
            m_last_j   = jj;
        end
        pop    = rdy && (m_level > 0);
        pushed = 1'b0;
        if (cap && !frz) begin
            if (m_level < DEPTH || pop) pushed = 1'b1;
            else if (m_dropped < DMAX) m_dropped++;
        end
        m_level = m_level - int'(pop) + int'(pushed);
        e.i  = ii;
        e.j  = jj;
        e.ts = m_ts;
        m_ts = (m_ts + 1) % (1 << TSW);

        @(posedge clk);
        #1;
        if (pushed) exp_q.push_back(e);
        check("level", level, m_level);
        check("dropped", dropped, m_dropped);
        check("step_err", step_err, m_step);
    endtask

    // Monitor: compare the head against the scoreboard, pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0 && out_valid) begin
                check("out_i", out_i, exp_q[0].i);
                check("out_j", out_j, exp_q[0].j);
                check("out_ts", out_ts, exp_q[0].ts);
            end
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // 1: first sample after reset is captured with ts 0.
        do_reset();
        cycle(1, 5, 9, 0, 0);
        check("t1_out_ts", out_ts, 0);
        check("t1_out_i", out_i, 5);
        cycle(0, 0, 0, 0, 1);

        // 2: four consecutive values, then repeats produce nothing.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1, k, 7, 0, 1);
        for (int k = 0; k < 3; k++) cycle(1, 3, 7, 0, 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 1);
        check("t2_level", level, 0);

        // 3: overflow with consumer stalled.
        do_reset();
        for (int k = 0; k < 20; k++) cycle(1, k, k * 3, 0, 0);
        check("t3_level", level, 16);
        check("t3_dropped", dropped, 4);

        // 4: push and pop together while full.
        cycle(1, 20, 99, 0, 1);
        check("t4_level", level, 16);
        check("t4_dropped", dropped, 4);
        for (int k = 0; k < 20; k++) cycle(0, 0, 0, 0, 1);
        check("t4_drained", level, 0);

        // Freeze discards a capture but still moves the reference pair.
        do_reset();
        cycle(1, 1, 1, 0, 1);
        cycle(1, 2, 2, 1, 1);
        cycle(1, 2, 2, 0, 1);
        cycle(1, 3, 3, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("frz_level", level, 0);

        // 5: wrap is legal, a jump is sticky.
        do_reset();
        cycle(1, 'h7FFE, 1, 0, 1);
        cycle(1, 'h7FFF, 1, 0, 1);
        cycle(1, 'h0000, 1, 0, 1);
        check("t5_wrap_ok", step_err, 0);
        cycle(1, 'h0005, 1, 0, 1);
        check("t5_jump", step_err, 1);
        cycle(1, 'h0006, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("t5_sticky", step_err, 1);

        // 6: reset mid-drain, then an equal pair is still captured.
        do_reset();
        for (int k = 0; k < 9; k++) cycle(1, k, 100, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("t6_level_pre", level, 7);
        do_reset();
        cycle(1, 8, 100, 0, 1);
        check("t6_recapture", level, 1);
        cycle(0, 0, 0, 0, 1);

        // Randomized run with varying consumer back-pressure.
        do_reset();
        begin
            int ci = $urandom_range(0, (1 << W) - 1);
            int cj = $urandom_range(0, (1 << W) - 1);
            for (int n = 0; n < 3000; n++) begin
                int  r    = $urandom_range(0, 99);
                int  rate = ((n / 200) % 3 == 1) ? 10 : 70;
                bit  v    = ($urandom_range(0, 3) != 0);
                bit  frz  = ($urandom_range(0, 9) == 0);
                bit  rdy  = ($urandom_range(0, 99) < rate);
                if (r >= 98) ci = $urandom_range(0, (1 << W) - 1);
                else if (r >= 50) ci = (ci + 1) % (1 << W);
                if ($urandom_range(0, 3) == 0) cj = $urandom_range(0, (1 << W) - 1);
                cycle(v, ci, cj, frz, rdy);
            end
        end
        for (int k = 0; k < 40; k++) cycle(0, 0, 0, 0, 1);
        check("final_empty", level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
